// File: rtl/write_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : write_sram_arb
// Purpose  : Round-robin arbiter that drains one full block per grant from the
//            per-port input FIFOs into the shared SRAM write port.
// Revision : 1.0 - initial release
// ============================================================================
module write_sram_arb #(
  parameter int PORT_NUM       = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int BLK_ADDR_WIDTH = 10,
  parameter int BLK_WORDS      = 32,
  parameter int CNT_WIDTH      = $clog2(BLK_WORDS)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [PORT_NUM-1:0]                 i_req,
  input  logic [PORT_NUM*BLK_ADDR_WIDTH-1:0]  i_blk_addr,
  input  logic [PORT_NUM*DATA_WIDTH-1:0]      i_fifo_data,
  output logic [PORT_NUM-1:0]                 o_fifo_ren,
  output logic [PORT_NUM-1:0]                 o_grant,
  output logic [PORT_NUM-1:0]                 o_done,
  output logic                                o_busy,
  output logic                                o_sram_wen,
  output logic [BLK_ADDR_WIDTH+CNT_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0]               o_sram_data
);

  localparam int PTR_WIDTH = $clog2(PORT_NUM);
  localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(BLK_WORDS - 1);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(PORT_NUM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t                    state, state_next;
  logic [PTR_WIDTH-1:0]      ptr, cand, win_idx, grant_idx;
  logic                      win_found;
  logic [CNT_WIDTH-1:0]      rd_cnt, wr_cnt;
  logic [BLK_ADDR_WIDTH-1:0] blk_addr;
  logic [PORT_NUM-1:0]       grant, ren, done;
  logic                      busy, wen;
  logic [DATA_WIDTH-1:0]     sram_data;

  // First requester at or above the priority pointer, searching upward with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      cand = PTR_WIDTH'((int'(ptr) + i) % PORT_NUM);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = READ;
      READ:    if (rd_cnt == RD_LAST) state_next = LAST;
      LAST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant     <= '0;
      ren       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      wen       <= 1'b0;
      ptr       <= '0;
      grant_idx <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      blk_addr  <= '0;
    end else begin
      busy <= (state_next != IDLE);
      wen  <= |ren;
      done <= '0;
      if (wen) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
      case (state)
        IDLE: begin
          if (win_found) begin
            grant     <= PORT_NUM'(1) << win_idx;
            ren       <= PORT_NUM'(1) << win_idx;
            grant_idx <= win_idx;
            blk_addr  <= i_blk_addr[win_idx*BLK_ADDR_WIDTH +: BLK_ADDR_WIDTH];
            rd_cnt    <= '0;
          end
        end
        READ: begin
          rd_cnt <= rd_cnt + CNT_WIDTH'(1);
          if (rd_cnt == RD_LAST) begin
            ren  <= '0;
            done <= grant;  // lands on the cycle carrying the final write
          end
        end
        LAST: begin
          grant <= '0;
          ptr   <= (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sram_data = '0;
    for (int p = 0; p < PORT_NUM; p++)
      sram_data = sram_data | (i_fifo_data[p*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[p]}});
  end

  assign o_fifo_ren  = ren;
  assign o_grant     = grant;
  assign o_done      = done;
  assign o_busy      = busy;
  assign o_sram_wen  = wen;
  assign o_sram_addr = {blk_addr, wr_cnt};
  assign o_sram_data = sram_data;

endmodule
`default_nettype wire

// File: tb/tb_write_sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_sram_arb
// Purpose  : Directed self-checking bench for write_sram_arb (32- and 2-word blocks).
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_sram_arb;
  localparam int PN = 4, DW = 32, BAW = 10, BW = 32, CW = 5, BW2 = 2, CW2 = 1;

  logic clk = 1'b0;
  logic rst;
  logic [PN-1:0]     req, ren, grant, done;
  logic [PN*BAW-1:0] blk_addr;
  logic [PN*DW-1:0]  fifo_data;
  logic              busy, wen;
  logic [BAW+CW-1:0] addr;
  logic [DW-1:0]     data;

  logic [PN-1:0]      req2, ren2, grant2, done2;
  logic [PN*BAW-1:0]  blk_addr2;
  logic [PN*DW-1:0]   fifo_data2;
  logic               busy2, wen2;
  logic [BAW+CW2-1:0] addr2;
  logic [DW-1:0]      data2;

  int total = 0, passed = 0;
  int rd_ptr[PN];
  int rd_ptr2[PN];

  write_sram_arb #(.PORT_NUM(PN), .DATA_WIDTH(DW), .BLK_ADDR_WIDTH(BAW), .BLK_WORDS(BW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_blk_addr(blk_addr), .i_fifo_data(fifo_data),
    .o_fifo_ren(ren), .o_grant(grant), .o_done(done), .o_busy(busy),
    .o_sram_wen(wen), .o_sram_addr(addr), .o_sram_data(data));

  write_sram_arb #(.PORT_NUM(PN), .DATA_WIDTH(DW), .BLK_ADDR_WIDTH(BAW), .BLK_WORDS(BW2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_req(req2), .i_blk_addr(blk_addr2), .i_fifo_data(fifo_data2),
    .o_fifo_ren(ren2), .o_grant(grant2), .o_done(done2), .o_busy(busy2),
    .o_sram_wen(wen2), .o_sram_addr(addr2), .o_sram_data(data2));

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int p, input int n);
    return 32'((p << 16) | (n + 1));
  endfunction

  // Non-FWFT FIFO models: dout valid the cycle after a read enable.
  always @(posedge clk) begin
    if (rst) begin
      fifo_data  <= '0;
      fifo_data2 <= '0;
      for (int p = 0; p < PN; p++) begin
        rd_ptr[p]  <= 0;
        rd_ptr2[p] <= 0;
      end
    end else begin
      for (int p = 0; p < PN; p++) begin
        if (ren[p]) begin
          fifo_data[p*DW +: DW] <= word(p, rd_ptr[p]);
          rd_ptr[p] <= rd_ptr[p] + 1;
        end
        if (ren2[p]) begin
          fifo_data2[p*DW +: DW] <= word(p, rd_ptr2[p]);
          rd_ptr2[p] <= rd_ptr2[p] + 1;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req = '0; req2 = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; req2 = 4'b1111;
    blk_addr = {4{10'h3FF}}; blk_addr2 = {4{10'h3FF}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (grant !== 4'b0) $display("FAIL reset_grant: got %b expected 0000", grant); else passed++;
    total++; if (ren !== 4'b0) $display("FAIL reset_ren: got %b expected 0000", ren); else passed++;
    total++; if (done !== 4'b0) $display("FAIL reset_done: got %b expected 0000", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (wen !== 1'b0) $display("FAIL reset_wen: got %b expected 0", wen); else passed++;
    total++; if (addr !== '0) $display("FAIL reset_addr: got %h expected 0", addr); else passed++;
    total++; if (data !== '0) $display("FAIL reset_data: got %h expected 0", data); else passed++;
    total++; if (grant2 !== 4'b0) $display("FAIL reset_grant2: got %b expected 0000", grant2); else passed++;
    rst = 1'b0; req = '0; req2 = '0;
  endtask

  task automatic test_single();
    logic [3:0] e_ren, e_done, e_grant;
    logic e_wen, e_busy;
    do_reset();
    blk_addr = {10'h3A1, 10'h005, 10'h111, 10'h222};
    req = 4'b0100;
    @(posedge clk);
    for (int k = 1; k <= BW + 2; k++) begin
      @(negedge clk);
      if (k == 1) req = 4'b0000;
      e_ren   = (k <= BW) ? 4'b0100 : 4'b0000;
      e_wen   = (k >= 2 && k <= BW + 1);
      e_done  = (k == BW + 1) ? 4'b0100 : 4'b0000;
      e_grant = (k <= BW + 1) ? 4'b0100 : 4'b0000;
      e_busy  = (k <= BW + 1);
      total++; if (ren !== e_ren) $display("FAIL single_ren k=%0d: got %b expected %b", k, ren, e_ren); else passed++;
      total++; if (wen !== e_wen) $display("FAIL single_wen k=%0d: got %b expected %b", k, wen, e_wen); else passed++;
      total++; if (done !== e_done) $display("FAIL single_done k=%0d: got %b expected %b", k, done, e_done); else passed++;
      total++; if (grant !== e_grant) $display("FAIL single_grant k=%0d: got %b expected %b", k, grant, e_grant); else passed++;
      total++; if (busy !== e_busy) $display("FAIL single_busy k=%0d: got %b expected %b", k, busy, e_busy); else passed++;
      if (e_wen) begin
        total++; if (addr !== {10'h005, 5'(k - 2)}) $display("FAIL single_addr k=%0d: got %h expected %h", k, addr, {10'h005, 5'(k - 2)}); else passed++;
        total++; if (data !== word(2, k - 2)) $display("FAIL single_data k=%0d: got %h expected %h", k, data, word(2, k - 2)); else passed++;
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$], lens[$], gaps[$];
    int wcount[PN];
    int ren_len, gap, cur, nblk, cyc;
    bit in_ren;
    do_reset();
    blk_addr = {10'h013, 10'h012, 10'h011, 10'h010};
    req = 4'b1111;
    ren_len = 0; gap = 0; nblk = 0; cyc = 0; in_ren = 1'b0;
    for (int p = 0; p < PN; p++) wcount[p] = 0;
    while (nblk < 5 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      total++; if ($countones(grant) > 1) $display("FAIL rr_onehot cyc=%0d: got %b expected at most one bit", cyc, grant); else passed++;
      if (|ren) begin
        if (!in_ren) begin
          in_ren = 1'b1;
          if (nblk > 0) gaps.push_back(gap);
          ren_len = 0;
          for (int p = 0; p < PN; p++) if (ren[p]) order.push_back(p);
        end
        ren_len++;
      end else begin
        if (in_ren) begin
          in_ren = 1'b0;
          lens.push_back(ren_len);
          nblk++;
          gap = 0;
        end
        gap++;
      end
      if (wen) begin
        cur = -1;
        for (int p = 0; p < PN; p++) if (grant[p]) cur = p;
        total++;
        if (cur < 0) $display("FAIL rr_wen_grant cyc=%0d: got grant %b expected one-hot", cyc, grant);
        else if (addr[14:5] !== 10'(16 + cur) || data !== word(cur, wcount[cur]))
          $display("FAIL rr_write cyc=%0d: got addr %h data %h expected blk %h data %h", cyc, addr, data, 10'(16 + cur), word(cur, wcount[cur]));
        else passed++;
        if (cur >= 0) wcount[cur]++;
      end
    end
    total++; if (nblk != 5) $display("FAIL rr_timeout: got %0d blocks expected 5", nblk); else passed++;
    total++; if (order.size() != 5) $display("FAIL rr_order_len: got %0d expected 5", order.size()); else passed++;
    for (int i = 0; i < order.size(); i++) begin
      total++; if (order[i] != i % PN) $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], i % PN); else passed++;
    end
    for (int i = 0; i < lens.size(); i++) begin
      total++; if (lens[i] != BW) $display("FAIL rr_len[%0d]: got %0d expected %0d", i, lens[i], BW); else passed++;
    end
    for (int i = 0; i < gaps.size(); i++) begin
      total++; if (gaps[i] != 2) $display("FAIL rr_gap[%0d]: got %0d expected 2", i, gaps[i]); else passed++;
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    blk_addr = {10'h033, 10'h022, 10'h011, 10'h0AB};
    req = 4'b0001;
    n = 0;
    while (!(wen === 1'b1 && addr[4:0] === 5'd10) && n < 100) begin
      @(negedge clk); n++;
    end
    total++; if (n >= 100) $display("FAIL mid_reach_write10: got timeout expected write 10"); else passed++;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (grant !== 4'b0) $display("FAIL mid_grant: got %b expected 0000", grant); else passed++;
    total++; if (ren !== 4'b0) $display("FAIL mid_ren: got %b expected 0000", ren); else passed++;
    total++; if (done !== 4'b0) $display("FAIL mid_done: got %b expected 0000", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else passed++;
    total++; if (wen !== 1'b0) $display("FAIL mid_wen: got %b expected 0", wen); else passed++;
    total++; if (addr !== '0) $display("FAIL mid_addr: got %h expected 0", addr); else passed++;
    total++; if (data !== '0) $display("FAIL mid_data: got %h expected 0", data); else passed++;
    rst = 1'b0;
    req = 4'b1001;
    @(posedge clk); @(negedge clk);
    total++; if (grant !== 4'b0001) $display("FAIL mid_tie_grant: got %b expected 0001", grant); else passed++;
    total++; if (addr[14:5] !== 10'h0AB) $display("FAIL mid_tie_blk: got %h expected 0ab", addr[14:5]); else passed++;
    do_reset();
    req = 4'b1000;
    @(posedge clk); @(negedge clk);
    total++; if (grant !== 4'b1000) $display("FAIL mid_port3_grant: got %b expected 1000", grant); else passed++;
    req = '0;
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    blk_addr = {10'h0C3, 10'h0C2, 10'h0C1, 10'h0C0};
    req = 4'b0010;
    n = 0;
    while (done !== 4'b0010 && n < 100) begin @(negedge clk); n++; end
    total++; if (n >= 100) $display("FAIL wrap_done1: got timeout expected done 0010"); else passed++;
    req = 4'b1010;
    @(negedge clk); @(negedge clk);
    total++; if (grant !== 4'b1000) $display("FAIL wrap_grant3: got %b expected 1000", grant); else passed++;
    n = 0;
    while (done !== 4'b1000 && n < 100) begin @(negedge clk); n++; end
    total++; if (n >= 100) $display("FAIL wrap_done3: got timeout expected done 1000"); else passed++;
    req = 4'b0011;
    @(negedge clk); @(negedge clk);
    total++; if (grant !== 4'b0001) $display("FAIL wrap_grant0: got %b expected 0001", grant); else passed++;
    req = '0;
  endtask

  task automatic test_ignore();
    int writes, dones;
    do_reset();
    blk_addr = {10'h000, 10'h2AA, 10'h000, 10'h000};
    req = 4'b0100;
    @(posedge clk);
    writes = 0; dones = 0;
    for (int k = 1; k <= BW + 2; k++) begin
      @(negedge clk);
      req = 4'($urandom);
      blk_addr = {4{10'h155}};
      if (k <= BW + 1) begin
        total++; if (grant !== 4'b0100) $display("FAIL ign_grant k=%0d: got %b expected 0100", k, grant); else passed++;
      end
      if (wen === 1'b1) begin
        writes++;
        total++; if (addr[14:5] !== 10'h2AA) $display("FAIL ign_blk k=%0d: got %h expected 2aa", k, addr[14:5]); else passed++;
      end
      if (done === 4'b0100) dones++;
    end
    total++; if (writes != BW) $display("FAIL ign_writes: got %0d expected %0d", writes, BW); else passed++;
    total++; if (dones != 1) $display("FAIL ign_dones: got %0d expected 1", dones); else passed++;
    req = '0;
  endtask

  task automatic test_small();
    logic [3:0] e_ren, e_done;
    logic e_wen;
    int off, widx;
    do_reset();
    blk_addr2 = {10'h000, 10'h000, 10'h000, 10'h003};
    req2 = 4'b0001;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) req2 = 4'b0000;
      e_ren  = (k == 1 || k == 2 || k == 5 || k == 6) ? 4'b0001 : 4'b0000;
      e_wen  = (k == 2 || k == 3 || k == 6 || k == 7);
      e_done = (k == 3 || k == 7) ? 4'b0001 : 4'b0000;
      off    = (k <= 3) ? k - 2 : k - 6;
      widx   = (k <= 3) ? k - 2 : k - 4;
      total++; if (ren2 !== e_ren) $display("FAIL small_ren k=%0d: got %b expected %b", k, ren2, e_ren); else passed++;
      total++; if (wen2 !== e_wen) $display("FAIL small_wen k=%0d: got %b expected %b", k, wen2, e_wen); else passed++;
      total++; if (done2 !== e_done) $display("FAIL small_done k=%0d: got %b expected %b", k, done2, e_done); else passed++;
      if (e_wen) begin
        total++; if (addr2 !== {10'h003, 1'(off)}) $display("FAIL small_addr k=%0d: got %h expected %h", k, addr2, {10'h003, 1'(off)}); else passed++;
        total++; if (data2 !== word(0, widx)) $display("FAIL small_data k=%0d: got %h expected %h", k, data2, word(0, widx)); else passed++;
      end
    end
  endtask

  initial begin
    req = '0; req2 = '0; blk_addr = '0; blk_addr2 = '0; rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_reset_mid();
    test_wrap();
    test_ignore();
    test_small();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion, %0d/%0d passed so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/write_sram_arb.md
# write_sram_arb

Round-robin arbiter and sequencer that shares the single SRAM write path of the multi-port cache between `PORT_NUM` ingress ports. Each port owns a non-FWFT input FIFO and raises a request once it holds a complete block and a free block address. The block grants one port at a time, drains exactly `BLK_WORDS` words from that port's FIFO, and drives word-addressed SRAM writes. It sits between the per-port input FIFOs / free-block allocator and the SRAM write port.

## Interface
- `PORT_NUM`, 4, number of requesting ingress ports (≥2)
- `DATA_WIDTH`, 32, FIFO / SRAM word width
- `BLK_ADDR_WIDTH`, 10, block address width from the allocator
- `BLK_WORDS`, 32, words per block; power of two, ≥2
- `CNT_WIDTH`, $clog2(BLK_WORDS), word-offset width (derived; do not override)

- `i_clk`  in  1  single clock; all logic on rising edge
- `i_rst`  in  1  synchronous, active-high reset
- `i_req`  in  PORT_NUM  per port: FIFO holds ≥ BLK_WORDS words and `i_blk_addr` slice is valid
- `i_blk_addr`  in  PORT_NUM*BLK_ADDR_WIDTH  per-port target block address; port p at bits [p*BLK_ADDR_WIDTH +: BLK_ADDR_WIDTH]
- `i_fifo_data`  in  PORT_NUM*DATA_WIDTH  per-port FIFO dout; valid one cycle after that port's read enable
- `o_fifo_ren`  out  PORT_NUM  one-hot FIFO read enable of the granted port
- `o_grant`  out  PORT_NUM  one-hot grant, held for the whole block
- `o_done`  out  PORT_NUM  one-cycle pulse on the granted port's bit when its last word is written
- `o_busy`  out  1  high whenever state ≠ IDLE
- `o_sram_wen`  out  1  SRAM write enable
- `o_sram_addr`  out  BLK_ADDR_WIDTH+CNT_WIDTH  {block address, word offset}
- `o_sram_data`  out  DATA_WIDTH  write data

## Operation
- States: IDLE, READ, LAST.
- IDLE: if any `i_req` bit is set, pick the winner by round-robin, register `o_grant`, latch its `i_blk_addr` slice, clear the read counter, and go to READ. Otherwise stay in IDLE.
- Round-robin: after reset, port 0 has highest priority. After port k completes, priority starts at (k+1) mod PORT_NUM and searches upward with wrap. Pointer updates only on completion.
- READ: `o_fifo_ren` = `o_grant`. Read counter counts 0..BLK_WORDS-1. When the counter reaches BLK_WORDS-1, go to LAST.
- Write pipeline: `o_sram_wen` is the read-active flag delayed one cycle. `o_sram_data` is the granted port's `i_fifo_data` slice. `o_sram_addr` = {latched block address, write counter}.
- The write counter increments per write and wraps from BLK_WORDS-1 to 0. Word offset is unsigned, no carry into the block field.
- LAST: the final write is issued, `o_done` pulses for the granted port, and the state returns to IDLE. `o_grant` clears on leaving LAST.
- `i_req` is sampled only in IDLE. Changes during READ/LAST are ignored. `i_blk_addr` is used only at grant time.
- Requesters must present updated `i_req` in the cycle after `o_done`; the arbiter samples it in the IDLE cycle that follows.
- Reset at any time, including mid-block: state becomes IDLE, the pointer returns to port 0, and all outputs go to 0 on the next edge. A partially written block is abandoned, and upstream FIFOs are reset by the same `i_rst`.
- A grant never targets a port whose `i_req` is low. No FIFO underflow is possible, because a request guarantees BLK_WORDS words.

## Timing
- Reset values: `o_fifo_ren`, `o_grant`, `o_done`, `o_busy`, `o_sram_wen` = 0; `o_sram_addr`, `o_sram_data` = 0.
- Request seen in IDLE at edge t:
  - `o_grant`/`o_busy` rise in cycle t+1.
  - `o_fifo_ren` is high in cycles t+1 … t+BLK_WORDS.
  - `o_sram_wen` is high in cycles t+2 … t+BLK_WORDS+1, offsets 0..BLK_WORDS-1.
- `o_done` is high in cycle t+BLK_WORDS+1, coincident with the last write. IDLE is in cycle t+BLK_WORDS+2.
- Back-to-back blocks: the next `o_fifo_ren` starts in cycle t+BLK_WORDS+3. That gives 2 non-writing cycles between blocks and 2 dead cycles of throughput per block.
- All outputs are registered except `o_sram_data`, which is a mux of `i_fifo_data` by the registered grant.

## Test plan
- Single request, port 2 with `i_blk_addr`=0x005, FIFO preloaded 1..32 → 32 writes to addr 0x0A0..0x0BF with data 1..32. `o_done[2]` coincides with the write of 32 to 0x0BF. Total 34 cycles from grant to IDLE.
- All four ports requesting continuously → grant order 0,1,2,3,0. Each grant is exactly 32 `o_fifo_ren` cycles with a 2-cycle gap, and `o_grant` is never multi-hot.
- Ports 1 and 3 requesting after port 1 was last served → port 3 granted before port 1 (pointer wrap).
- Reset asserted at write 10 of a block → the next cycle all outputs are 0 and the state is IDLE. A new request on port 3 is then granted ahead of port 0 only if port 0 is idle (port 0 wins ties).
- `i_req` toggled and `i_blk_addr` changed during READ → no effect. The address stays latched and the block completes normally.
- BLK_WORDS=2 build → write offsets 0,1. `o_done` is in cycle t+3, and the offset wraps correctly on the next block.
